contador_ctrl: RTL and testbench

Sequencer for the up/down counter `contador`: it drives the counter's `up`/`down` inputs to produce triangular sweeps between two programmable limits.
- Adds a step-rate prescaler, dwell time at each end, and a programmable sweep count.
- Reads the counter value back through `count_in` for closed-loop limit detection.
- Sits between the control logic (buttons or a host FSM) and the `contador` instance.

---
 rtl/contador_ctrl.sv | 177 +++++++++++++++++
 tb/tb_contador_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_ctrl.sv
// contador_ctrl: sequences an up/down counter through triangular sweeps between two limits.
// Defining CONTADOR_CTRL_PAUSE_EN adds a pause input that freezes the sequence in place.
module contador_ctrl #(
    parameter int unsigned W     = 4,
    parameter int unsigned PRESC = 4,
    parameter int unsigned HOLD  = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
`ifdef CONTADOR_CTRL_PAUSE_EN
    input  logic         pause,
`endif
    input  logic [W-1:0] lo_lim,
    input  logic [W-1:0] hi_lim,
    input  logic [7:0]   n_sweeps,
    input  logic [W-1:0] count_in,
    output logic         up,
    output logic         down,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(PRESC - 1);
    localparam logic [HW-1:0] HoldLast  = HW'(HOLD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StUp,
        StHoldHi,
        StDown,
        StHoldLo
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    sweep_q, sweep_d;
    logic [7:0]    nsw_q, nsw_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          frozen;
    logic          tick;
    logic          hold_end;

`ifdef CONTADOR_CTRL_PAUSE_EN
    assign frozen = pause & (state_q != StIdle);
`else
    assign frozen = 1'b0;
`endif

    assign tick     = (state_q != StIdle) && !frozen && (presc_q == PrescLast);
    assign hold_end = (hold_q == HoldLast);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hold_d  = hold_q;
        sweep_d = sweep_q;
        nsw_d   = nsw_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        done_d  = 1'b0;
        up      = 1'b0;
        down    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    lo_d    = lo_lim;
                    hi_d    = hi_lim;
                    nsw_d   = n_sweeps;
                    sweep_d = '0;
                    hold_d  = '0;
                    if (lo_lim > hi_lim) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StUp;
                    end
                end
            end
            StUp: begin
                if (tick) begin
                    if (count_in >= hi_q) state_d = StHoldHi;
                    else                  up      = 1'b1;
                end
            end
            StHoldHi: begin
                if (tick) begin
                    if (hold_end) begin
                        hold_d  = '0;
                        state_d = StDown;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            StDown: begin
                if (tick) begin
                    if (count_in <= lo_q) state_d = StHoldLo;
                    else                  down    = 1'b1;
                end
            end
            StHoldLo: begin
                if (tick) begin
                    if (hold_end) begin
                        hold_d = '0;
                        // A zero sweep count never matches, so continuous mode loops forever.
                        if (nsw_q != 8'd0 && 8'(sweep_q + 8'd1) == nsw_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            sweep_d = sweep_q + 8'd1;
                            state_d = StUp;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // State only changes on a tick, so wrapping here also clears on every state entry.
        if (state_q == StIdle || tick) begin
            presc_d = '0;
        end else if (!frozen) begin
            presc_d = presc_q + PW'(1);
        end

        if (stop && state_q != StIdle) begin
            state_d = StIdle;
            presc_d = '0;
            hold_d  = '0;
            done_d  = 1'b0;
            up      = 1'b0;
            down    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            hold_q  <= '0;
            sweep_q <= '0;
            nsw_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            sweep_q <= sweep_d;
            nsw_q   <= nsw_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: a counter model closes the loop; a tick-level sweep schedule
// derived from the limits predicts every cycle's up/down/busy/done.
module tb_contador_ctrl;

    localparam int W     = 4;
    localparam int PRESC = 4;
    localparam int HOLD  = 3;
`ifdef CONTADOR_CTRL_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic         stop;
    logic         pause;
    logic [W-1:0] lo_lim;
    logic [W-1:0] hi_lim;
    logic [7:0]   n_sweeps;
    logic [W-1:0] count_in;
    logic         up;
    logic         down;
    logic         busy;
    logic         done;
    logic         err;

    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_dly;

    int checks;
    int errors;

    contador_ctrl #(
        .W    (W),
        .PRESC(PRESC),
        .HOLD (HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
`ifdef CONTADOR_CTRL_PAUSE_EN
        .pause   (pause),
`endif
        .lo_lim  (lo_lim),
        .hi_lim  (hi_lim),
        .n_sweeps(n_sweeps),
        .count_in(count_in),
        .up      (up),
        .down    (down),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The counter under control: count changes on the edge after a pulse and reaches
    // count_in one cycle later.
    always @(posedge clk) begin
        if (load) begin
            cnt     <= load_val;
            cnt_dly <= load_val;
        end else begin
            if (up)        cnt <= cnt + 4'd1;
            else if (down) cnt <= cnt - 4'd1;
            cnt_dly <= cnt;
        end
    end
    assign count_in = cnt_dly;

    task automatic check(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int outs();
        return int'({up, down, busy, done});
    endfunction

    task automatic preload(input int v);
        @(posedge clk); #1;
        load     = 1'b1;
        load_val = 4'(v);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Output vector encoding {up,down,busy,done}: 10 = up pulse, 6 = down pulse,
    // 2 = busy without pulse, 1 = done, 0 = idle.
    task automatic run_seq(input string name, input int c0, input int lo, input int hi,
                           input int n, input int stop_at, input int p0, input int plen);
        int  ev[$];
        int  cur, e, tk, exp_cnt, sweeps, v, exp_v;
        bit  ended, done_next, fin;
        preload(c0);
        ev     = {};
        sweeps = (n == 0) ? 4 : n;
        cur    = c0;
        for (int s = 0; s < sweeps; s++) begin
            while (cur < hi) begin ev.push_back(1); cur++; end
            ev.push_back(0);
            repeat (HOLD) ev.push_back(0);
            while (cur > lo) begin ev.push_back(-1); cur--; end
            ev.push_back(0);
            repeat (HOLD) ev.push_back(0);
        end

        @(posedge clk); #1;
        start    = 1'b1;
        lo_lim   = 4'(lo);
        hi_lim   = 4'(hi);
        n_sweeps = 8'(n);
        @(negedge clk);
        check($sformatf("%s cyc0", name), outs(), 0);

        e = 0; tk = 0; exp_cnt = c0; ended = 0; done_next = 0; fin = 0;
        for (int c = 1; c < 4000 && !fin; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            stop  = (c == stop_at);
            pause = (c >= p0) && (c < p0 + plen);
            @(negedge clk);
            if (ended) begin
                exp_v = done_next ? 1 : 0;
                fin   = 1;
            end else if (stop) begin
                exp_v = 2;
                ended = 1;
            end else if (HAS_PAUSE && pause) begin
                exp_v = 2;
            end else begin
                e++;
                exp_v = 2;
                if (e % PRESC == 0 && tk < ev.size()) begin
                    v = ev[tk];
                    tk++;
                    exp_cnt += v;
                    if (v == 1)       exp_v = 10;
                    else if (v == -1) exp_v = 6;
                    if (tk == ev.size()) begin
                        ended     = 1;
                        done_next = (n != 0);
                    end
                end
            end
            check($sformatf("%s cyc%0d", name, c), outs(), exp_v);
        end
        @(posedge clk); #1;
        stop  = 1'b0;
        pause = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check($sformatf("%s count", name), int'(count_in), exp_cnt);
        check($sformatf("%s err", name), int'(err), 0);
    endtask

    initial begin
        int lo, hi, c0, n;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        lo_lim   = '0;
        hi_lim   = '0;
        n_sweeps = '0;
        load     = 1'b1;
        load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        check("reset outs", outs(), 0);
        check("reset err", int'(err), 0);

        // Reset mid-sweep, with an ignored bad start while busy beforehand.
        preload(3);
        @(posedge clk); #1;
        start = 1'b1; lo_lim = 4'd3; hi_lim = 4'd9; n_sweeps = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        start = 1'b1; lo_lim = 4'd9; hi_lim = 4'd3;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy start ignored err", int'(err), 0);
        check("busy start ignored busy", int'(busy), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset outs", outs(), 0);
        check("midreset err", int'(err), 0);

        // Invalid limits set err; reset clears it.
        @(posedge clk); #1;
        start = 1'b1; lo_lim = 4'd9; hi_lim = 4'd3; n_sweeps = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("bad lim err", int'(err), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("bad lim idle%0d", i), outs(), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset clears err", int'(err), 0);

        run_seq("restart", 4, 2, 6, 1, -1, -1, 0);

        // Invalid start again, then a valid start must clear err.
        @(posedge clk); #1;
        start = 1'b1; lo_lim = 4'd9; hi_lim = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("bad lim err2", int'(err), 1);

        run_seq("basic", 2, 2, 5, 1, -1, -1, 0);
        run_seq("equal", 7, 7, 7, 2, -1, -1, 0);
        run_seq("outrange", 12, 1, 8, 1, -1, -1, 0);
        run_seq("contin", 0, 0, 15, 0, 470, -1, 0);
        run_seq("pause", 2, 2, 5, 1, -1, 6, 10);

        // stop and start together while idle.
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1; lo_lim = 4'd1; hi_lim = 4'd5; n_sweeps = 8'd1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("collide idle%0d", i), outs(), 0);
        end

        for (int r = 0; r < 6; r++) begin
            lo = $urandom_range(0, 15);
            hi = $urandom_range(lo, 15);
            c0 = $urandom_range(0, 15);
            n  = $urandom_range(1, 2);
            run_seq($sformatf("rnd%0d", r), c0, lo, hi, n, -1,
                    $urandom_range(2, 60), $urandom_range(1, 12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
